fetch_ctrl: RTL
===============

# fetch_ctrl

Program-counter and control-flow sequencer for the single-cycle core. It is the consumer side of the branch-target lookup:
- drives a 4-bit branch index and a read strobe to the target table;
- takes the returned 8-bit absolute address and steers the PC between sequential fetch and taken branches.

It also starts one of three resident programs, stops on halt, and reports an executed-instruction count for the testbench.

## Interface
- PROG0_START, 8'd0, start address of program 1
- PROG1_START, 8'd80, start address of program 2
- PROG2_START, 8'd128, start address of program 3
- CLK  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high; sampled on rising CLK
- start  input  1  one-cycle request to begin a program
- prog_sel  input  2  program select: 0/1/2 select PROG0/1/2; 3 is illegal
- branch_en  input  1  current instruction is a LUT branch
- branch_cond  input  1  branch condition from the ALU flags; taken = branch_en & branch_cond
- branch_idx  input  4  target-table index from the instruction field
- halt_req  input  1  current instruction is HALT
- lut_addr  input  8  target address returned combinationally by the table
- lut_idx  output  4  index to the table
- lut_rd  output  1  table read enable
- pc  output  8  instruction address
- running  output  1  high in RUN
- done  output  1  high in HALT
- pc_ovf  output  1  sticky; high when sequential fetch ran off address 255
- instr_cnt  output  16  instructions retired since the last accepted start; saturates at 16'hFFFF

## Operation
- States:
  - IDLE: reset state.
  - RUN: sequential fetch and branches.
  - HALT: stopped.
- Reset values: state=IDLE, pc=0, running=0, done=0, pc_ovf=0, instr_cnt=0.
- IDLE or HALT with start=1 and prog_sel≠3:
  - pc<=selected start address; instr_cnt<=0; pc_ovf<=0; state<=RUN.
- start with prog_sel=3 is ignored, with no state change.
- start during RUN is ignored.
- RUN, per cycle, in priority order:
  1. halt_req: state<=HALT; pc holds; instr_cnt+1.
  2. taken branch: pc<=lut_addr; instr_cnt+1.
  3. otherwise: pc<=pc+1 and instr_cnt+1.
     - If pc==255: pc<=0, pc_ovf<=1, state<=HALT. The retiring instruction is still counted.
- halt_req together with a taken branch: halt wins; pc does not move.
- Not-taken branch (branch_en=1, branch_cond=0) behaves as sequential fetch.
- lut_idx=branch_idx at all times.
- lut_rd=branch_en & running. It is combinational and never asserted outside RUN.
- instr_cnt saturates at 16'hFFFF and never wraps.
- HALT holds pc and instr_cnt; done=1 until the next accepted start or reset.
- Outputs running and done are decoded directly from the state register and are mutually exclusive.

## Timing
- All state updates happen on the rising CLK edge; no combinational path from start to pc.
- start sampled in cycle t: pc=start address and running=1 in cycle t+1.
- Branch resolved in cycle t: pc=lut_addr in cycle t+1. Zero-bubble: the table is combinational, and lut_addr must be stable before the edge.
- halt_req in cycle t: done=1 and running=0 in cycle t+1.
- reset overrides every input in the same cycle, including mid-program: the next cycle is IDLE with all reset values.
- Reset asserted together with start: reset wins; start is not remembered.

## Structure
- Shared package: state enum (IDLE, RUN, HALT), PC width (8), index width (4), counter width (16), and the three program start constants used as parameter defaults.
- One natural sub-module, pc_next_sel: combinational next-PC mux plus overflow detect, with inputs pc, taken, halt and lut_addr.
- The FSM, pc register and counter stay in fetch_ctrl.
- The target table is instantiated outside, beside fetch_ctrl, and connected through lut_idx/lut_rd/lut_addr.

## Test plan
- Reset, then start with prog_sel=1 → pc=80 and running=1 next cycle; idle inputs for 5 cycles → pc=85, instr_cnt=5.
- RUN, branch_en=1, branch_cond=1, branch_idx=4'b0000, table model returns 34 → lut_rd=1 that cycle, pc=34 next cycle; same with branch_cond=0 → pc=previous+1.
- halt_req and taken branch in the same cycle at pc=40 → done=1, pc stays 40; start with prog_sel=2 → pc=128, instr_cnt=0, running=1.
- Start with PROG0_START overridden to 8'd250; run sequentially to pc=255 → next cycle pc=0, pc_ovf=1, done=1, instr_cnt=6.
- Assert reset mid-program at pc=100 → next cycle pc=0, IDLE, all outputs at reset values. start with prog_sel=3 → no change; start during RUN → ignored.
- Preload instr_cnt near saturation via a long run (≥65535 cycles, looping branch) → instr_cnt holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: widths, state codes and program entry points.
package fetch_ctrl_pkg;

  localparam int unsigned PcW  = 8;
  localparam int unsigned IdxW = 4;
  localparam int unsigned CntW = 16;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [PcW-1:0] ProgStart0Default = 8'd0;
  localparam logic [PcW-1:0] ProgStart1Default = 8'd80;
  localparam logic [PcW-1:0] ProgStart2Default = 8'd128;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux for the RUN state: hold on halt, jump on taken branch, else step with wrap detect.
module pc_next_sel
  import fetch_ctrl_pkg::*;
(
  input  logic [PcW-1:0] pc,
  input  logic           taken,
  input  logic           halt,
  input  logic [PcW-1:0] lut_addr,
  output logic [PcW-1:0] pc_next,
  output logic           ovf
);

  always_comb begin
    pc_next = pc;
    ovf     = 1'b0;
    if (halt) begin
      pc_next = pc;
    end else if (taken) begin
      pc_next = lut_addr;
    end else begin
      pc_next = pc + PcW'(1);
      ovf     = (pc == '1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: starts a resident program, follows table branches, stops on halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PcW-1:0] PROG0_START = ProgStart0Default,
  parameter logic [PcW-1:0] PROG1_START = ProgStart1Default,
  parameter logic [PcW-1:0] PROG2_START = ProgStart2Default
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      prog_sel,
  input  logic            branch_en,
  input  logic            branch_cond,
  input  logic [IdxW-1:0] branch_idx,
  input  logic            halt_req,
  input  logic [PcW-1:0]  lut_addr,
  output logic [IdxW-1:0] lut_idx,
  output logic            lut_rd,
  output logic [PcW-1:0]  pc,
  output logic            running,
  output logic            done,
  output logic            pc_ovf,
  output logic [CntW-1:0] instr_cnt
);

  logic [1:0]      state_q;
  logic [PcW-1:0]  pc_q;
  logic            ovf_q;
  logic [CntW-1:0] cnt_q;

  logic [PcW-1:0]  pc_next;
  logic            seq_ovf;
  logic [PcW-1:0]  start_addr;
  logic            start_ok;
  logic            taken;

  assign taken    = branch_en & branch_cond;
  assign start_ok = start & (prog_sel != 2'd3);

  always_comb begin
    start_addr = PROG0_START;
    unique case (prog_sel)
      2'd1:    start_addr = PROG1_START;
      2'd2:    start_addr = PROG2_START;
      default: start_addr = PROG0_START;
    endcase
  end

  pc_next_sel u_pc_next_sel (
    .pc       (pc_q),
    .taken    (taken),
    .halt     (halt_req),
    .lut_addr (lut_addr),
    .pc_next  (pc_next),
    .ovf      (seq_ovf)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start_ok) begin
            state_q <= StRun;
            pc_q    <= start_addr;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          // Every RUN cycle retires one instruction, including the halting or wrapping one.
          pc_q  <= pc_next;
          cnt_q <= sat_inc(cnt_q);
          if (halt_req || seq_ovf) begin
            state_q <= StHalt;
          end
          if (seq_ovf) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running   = (state_q == StRun);
  assign done      = (state_q == StHalt);
  assign lut_idx   = branch_idx;
  assign lut_rd    = branch_en & running;
  assign pc        = pc_q;
  assign pc_ovf    = ovf_q;
  assign instr_cnt = cnt_q;

endmodule
